id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Hazard and forwarding controller for the ID stage of the 5-stage MIPS pipeline.
- Keeps its own shadow of the destinations in flight in EXE and MEM, and derives the ID operand forward selects (fwda/fwdb) from that shadow.
- Detects load-use and multi-cycle divide hazards; drives PC/IF-ID stall and EXE bubble insertion.
- Sits beside the ID decoder; its fwda/fwdb drive the ID operand muxes, replacing the fixed 2'b00 selects.

Parameters:
- DIV_CYCLES, 33, cycles the divider is busy after a divide issues (≥2)
- CNT_W, 6, divide counter width; must satisfy 2^CNT_W > DIV_CYCLES

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  rs field
- id_rt  in  5  rt field
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_write_regfile  in  1  instruction writes the register file
- id_mem_to_regfile  in  1  instruction is a load
- id_rn  in  5  destination register (rd or rt, already selected)
- id_is_div  in  1  DIV/DIVU
- id_use_hilo  in  1  MFHI/MFLO/MTHI/MTLO/MULT
- flush  in  1  kill the ID instruction (exception or redirect)
- stall  out  1  freeze PC and IF/ID register
- bubble  out  1  load a NOP into ID/EXE
- fwda  out  2  rs select: 0 regfile qa, 1 EXE ALU result, 2 MEM ALU result, 3 MEM load data
- fwdb  out  2  rt select, same encoding
- div_busy  out  1  divider occupied

Behaviour:
- Shadow state: exe_{v,wreg,m2reg,rn} and mem_{v,wreg,m2reg,rn}. Stages after ID never stall.
- Shadow update, every cycle:
  - mem_* <= exe_*
  - exe_* <= ID fields when id_valid & ~stall & ~flush; otherwise exe_v <= 0 (bubble)
- Forwarding (combinational from shadow + ID fields), computed for rs and for rt independently:
  - EXE match: exe_v & exe_wreg & exe_rn != 0 & exe_rn == src & ~exe_m2reg -> 1
  - else MEM match, same test on mem_* -> 2 if ~mem_m2reg, 3 if mem_m2reg
  - else 0
  - EXE has priority over MEM. Register 0 never forwards. If use_x is 0, the select is 0.
- Load-use hazard lu:
  - id_valid & exe_v & exe_wreg & exe_m2reg & exe_rn != 0 & ((id_use_rs & id_rs == exe_rn) | (id_use_rt & id_rt == exe_rn))
  - Lasts exactly 1 cycle: next cycle the load sits in MEM and forwards with code 3.
- Divide counter:
  - Loads DIV_CYCLES-1 when a div is accepted (id_valid & id_is_div & ~stall & ~flush).
  - Otherwise decrements while non-zero, saturating at 0.
  - div_busy = (cnt != 0).
  - Divide hazard dh = id_valid & div_busy & (id_is_div | id_use_hilo).
- Outputs:
  - stall = (lu | dh) & ~flush
  - bubble = stall | flush
  - flush has priority over every hazard. A flushed instruction is never recorded and never starts the counter. Flush does not clear an already running counter.
- Simultaneous lu and dh: single stall; each condition re-evaluates every cycle.
- Reset (reset == 0 at a clk edge): all shadow valids 0, counter 0. Consequently stall=0, bubble=0, fwda=fwdb=0, div_busy=0 in the cycle after reset. Reset mid-divide aborts the busy window.
- Latency: forward selects and stall are combinational from ID inputs and registered shadow. No added pipeline delay.

Decomposition:
- Shared package id_hazard_pkg:
  - FWD_RF=2'd0, FWD_EXE_ALU=2'd1, FWD_MEM_ALU=2'd2, FWD_MEM_LOAD=2'd3
  - REG_ZERO=5'd0
  - stage shadow record typedef {v, wreg, m2reg, rn[4:0]}
- One sub-module: div_busy_counter (load, count-down, busy flag), parameterised by DIV_CYCLES/CNT_W.
- Forward-select logic is a function in the package, called once for rs and once for rt.

Test Plan:
- ALU back-to-back: addu $3 issued, next instr reads rs=$3 -> fwda=1, stall=0. Cycle after (no new writer): fwda=2.
- Load-use: lw $5 issued, next instr use_rt rt=$5 -> stall=1, bubble=1 for exactly 1 cycle; following cycle stall=0, fwdb=3.
- Priority and $0: EXE and MEM both write $7, ID reads $7 -> fwda=1. Writer of $0 in EXE with ID reading $0 -> fwda=0.
- Divide: div accepted at cycle T with DIV_CYCLES=33 -> div_busy=1 for T+1..T+32. An mflo at T+1 stalls until T+32, proceeds at T+33. An unrelated addu in that window is not stalled.
- Flush override: load-use condition present with flush=1 -> stall=0, bubble=1, exe_v=0 next cycle. A flushed div leaves div_busy=0.
- Reset: reset=0 during a busy divide with a load in EXE -> next cycle div_busy=0, stall=0, fwda=fwdb=0 for any ID operands.

Source files
------------

// File: rtl/id_hazard_pkg.sv
// Shared types and forward-select helper for the ID-stage hazard controller.
package id_hazard_pkg;

    localparam logic [1:0] FWD_RF       = 2'd0;
    localparam logic [1:0] FWD_EXE_ALU  = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
    localparam logic [1:0] FWD_MEM_LOAD = 2'd3;
    localparam logic [4:0] REG_ZERO     = 5'd0;

    typedef struct packed {
        logic       v;
        logic       wreg;
        logic       m2reg;
        logic [4:0] rn;
    } stage_t;

    function automatic logic stage_hit(stage_t s, logic [4:0] src);
        return s.v & s.wreg & (s.rn != REG_ZERO) & (s.rn == src);
    endfunction

    // EXE wins over MEM; a load still in EXE cannot forward (load-use stall covers it).
    function automatic logic [1:0] fwd_sel(stage_t exe, stage_t mem, logic use_src, logic [4:0] src);
        if (!use_src)
            return FWD_RF;
        if (stage_hit(exe, src) && !exe.m2reg)
            return FWD_EXE_ALU;
        if (stage_hit(mem, src))
            return mem.m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_div_busy_counter.sv
// Divider occupancy counter: load starts a DIV_CYCLES-1 countdown, busy while non-zero.
// Busy is registered; no backpressure (load always accepted).
module div_busy_counter #(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/forwarding control from a shadow of EXE/MEM destinations.
// Selects and stall are combinational; stall freezes PC/IF-ID and a bubble fills ID/EXE.
module id_hazard_ctrl
    import id_hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_write_regfile,
    input  logic       id_mem_to_regfile,
    input  logic [4:0] id_rn,
    input  logic       id_is_div,
    input  logic       id_use_hilo,
    input  logic       flush,
    output logic       stall,
    output logic       bubble,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       div_busy
);

    stage_t exe_q;
    stage_t mem_q;
    stage_t id_st;
    logic   lu;
    logic   dh;
    logic   accept;

    always_comb begin
        id_st.v     = 1'b1;
        id_st.wreg  = id_write_regfile;
        id_st.m2reg = id_mem_to_regfile;
        id_st.rn    = id_rn;
    end

    assign lu = id_valid & exe_q.v & exe_q.wreg & exe_q.m2reg & (exe_q.rn != REG_ZERO) &
                ((id_use_rs & (id_rs == exe_q.rn)) | (id_use_rt & (id_rt == exe_q.rn)));
    assign dh = id_valid & div_busy & (id_is_div | id_use_hilo);

    assign stall  = (lu | dh) & ~flush;
    assign bubble = stall | flush;
    assign accept = id_valid & ~stall & ~flush;

    assign fwda = fwd_sel(exe_q, mem_q, id_use_rs, id_rs);
    assign fwdb = fwd_sel(exe_q, mem_q, id_use_rt, id_rt);

    // Later stages never stall, so the shadow always advances.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= exe_q;
            exe_q <= accept ? id_st : '0;
        end
    end

    div_busy_counter #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_busy_counter (
        .clk   (clk),
        .reset (reset),
        .load  (accept & id_is_div),
        .busy  (div_busy)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed scoreboard bench for id_hazard_ctrl (DIV_CYCLES=33).
module tb_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_write_regfile, id_mem_to_regfile;
    logic       id_is_div, id_use_hilo, flush;
    logic [4:0] id_rs, id_rt, id_rn;
    logic       stall, bubble, div_busy;
    logic [1:0] fwda, fwdb;

    typedef struct {
        logic       stall;
        logic       bubble;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       busy;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.DIV_CYCLES(33), .CNT_W(6)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rs             (id_rs),
        .id_rt             (id_rt),
        .id_use_rs         (id_use_rs),
        .id_use_rt         (id_use_rt),
        .id_write_regfile  (id_write_regfile),
        .id_mem_to_regfile (id_mem_to_regfile),
        .id_rn             (id_rn),
        .id_is_div         (id_is_div),
        .id_use_hilo       (id_use_hilo),
        .flush             (flush),
        .stall             (stall),
        .bubble            (bubble),
        .fwda              (fwda),
        .fwdb              (fwdb),
        .div_busy          (div_busy)
    );

    // Monitor: outputs are combinational, so every cycle with a pending expectation is checked mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (stall !== e.stall || bubble !== e.bubble || fwda !== e.fa ||
                fwdb !== e.fb || div_busy !== e.busy) begin
                bad++;
                $display("FAIL %s: got stall=%b bubble=%b fwda=%0d fwdb=%0d busy=%b, want stall=%b bubble=%b fwda=%0d fwdb=%0d busy=%b",
                         e.name, stall, bubble, fwda, fwdb, div_busy,
                         e.stall, e.bubble, e.fa, e.fb, e.busy);
            end
        end
    end

    task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic wr, input logic m2r,
                      input logic [4:0] rn, input logic dv, input logic hilo, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_write_regfile = wr; id_mem_to_regfile = m2r; id_rn = rn;
        id_is_div = dv; id_use_hilo = hilo; flush = fl;
    endtask

    task automatic chk(input string name, input logic s, input logic b,
                       input logic [1:0] fa, input logic [1:0] fb, input logic busy);
        exp_t e;
        e.stall = s; e.bubble = b; e.fa = fa; e.fb = fb; e.busy = busy; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // v  rs  rt urs urt wr m2r rn div hilo fl
        id(1,  3,  4, 1, 1, 0, 0,  0, 0, 0, 0); chk("reset_state",     0, 0, 0, 0, 0);
        id(1,  1,  2, 1, 1, 1, 0,  3, 0, 0, 0); chk("addu3_issue",     0, 0, 0, 0, 0);
        id(1,  3,  9, 1, 1, 1, 0, 10, 0, 0, 0); chk("fwd_exe_alu",     0, 0, 1, 0, 0);
        id(1,  3, 10, 1, 1, 0, 0,  0, 0, 0, 0); chk("fwd_mem_alu",     0, 0, 2, 1, 0);
        id(0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0); chk("idle",            0, 0, 0, 0, 0);
        id(1,  1,  0, 1, 0, 1, 1,  5, 0, 0, 0); chk("lw5_issue",       0, 0, 0, 0, 0);
        id(1,  0,  5, 0, 1, 1, 0,  6, 0, 0, 0); chk("load_use_stall",  1, 1, 0, 0, 0);
        chk("load_use_release", 0, 0, 0, 3, 0);
        id(1,  0,  0, 0, 0, 1, 0,  7, 0, 0, 0); chk("w7_first",        0, 0, 0, 0, 0);
        id(1,  7,  0, 1, 0, 1, 0,  7, 0, 0, 0); chk("w7_second",       0, 0, 1, 0, 0);
        id(1,  7,  0, 1, 1, 1, 0,  0, 0, 0, 0); chk("exe_over_mem",    0, 0, 1, 0, 0);
        id(1,  0,  0, 1, 1, 0, 0,  0, 0, 0, 0); chk("reg0_no_fwd",     0, 0, 0, 0, 0);
        id(1,  0,  0, 0, 0, 1, 1,  8, 0, 0, 0); chk("lw8_issue",       0, 0, 0, 0, 0);
        id(1,  8,  0, 1, 0, 1, 1,  8, 0, 0, 1); chk("flush_over_lu",   0, 1, 0, 0, 0);
        id(1,  8,  0, 1, 0, 0, 0,  0, 0, 0, 0); chk("flushed_not_kept",0, 0, 3, 0, 0);
        id(1,  0,  0, 0, 0, 0, 0,  0, 1, 0, 1); chk("div_flushed",     0, 1, 0, 0, 0);
        id(0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0); chk("div_flushed_idle",0, 0, 0, 0, 0);
        id(1,  1,  2, 1, 1, 0, 0,  0, 1, 0, 0); chk("div_accept",      0, 0, 0, 0, 0);
        id(1,  0,  0, 0, 0, 1, 0,  9, 0, 1, 0);
        for (int i = 1; i <= 32; i++)
            chk($sformatf("mflo_stall_t%0d", i), 1, 1, 0, 0, 1);
        chk("mflo_proceeds", 0, 0, 0, 0, 0);
        id(1,  1,  2, 1, 1, 0, 0,  0, 1, 0, 0); chk("div2_accept",     0, 0, 0, 0, 0);
        id(1,  1,  2, 1, 1, 1, 0, 11, 0, 0, 0); chk("addu_in_window",  0, 0, 0, 0, 1);
        id(1,  0,  0, 0, 0, 1, 1,  4, 0, 0, 0); chk("lw4_in_window",   0, 0, 0, 0, 1);
        id(1,  4,  4, 1, 1, 0, 0,  0, 0, 1, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_div_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1, "timeout");
    end

endmodule
